seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
- Parametrised multi-digit seven-segment display driver; the next generation of the single-digit decode/select/register display path.
- Captures a packed multi-digit value into a shadow register and time-multiplexes the digits onto one shared segment bus and per-digit anode lines.
- Adds programmable refresh rate, an anti-ghosting guard interval, per-digit blanking, decimal points, leading-zero suppression, lamp test and selectable output polarity.
- Sits between the datapath (counters/ALU results) and the board display pins.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles each digit is displayed (SHOW phase), >=2
GUARD, 2, clock cycles all anodes are off between digits, >=1
AN_ACTIVE_LOW, 1, 1: anode asserted = 0; 0: asserted = 1
SEG_ACTIVE_LOW, 1, 1: segment/dp lit = 0; 0: lit = 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
en  input  1  scan enable
load  input  1  single-cycle strobe: capture value/dp_in/blank_mask/lz_en into the shadow registers
value  input  4*DIGITS  packed hex nibbles; digit i = value[4i+3:4i]; digit 0 is least significant
dp_in  input  DIGITS  decimal point per digit
blank_mask  input  DIGITS  1 = force digit dark
lz_en  input  1  leading-zero suppression enable
lamp_test  input  1  light all segments and dp on the active digit
seg  output  7  {g,f,e,d,c,b,a}, registered
dp  output  1  decimal point, registered
an  output  DIGITS  anode drives, one-hot when asserted, registered
digit_idx  output  $clog2(DIGITS)  index of the digit currently shown, registered

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low.
- Reset (reset==0 at a rising edge) sets:
  - shadow registers to 0;
  - prescaler to 0 and digit_idx to 0;
  - FSM to GUARD with guard counter 0;
  - an to all deasserted, seg and dp to unlit, with polarity applied per parameters.
  - Reset overrides load, en and lamp_test.
- Shadow capture:
  - load==1 at an edge captures the inputs; they are visible on outputs from the next edge.
  - Capture occurs regardless of en.
  - Inputs are ignored when load==0.
- FSM (advances only when en==1):
  - GUARD: an all deasserted. The guard counter counts 0..GUARD-1. At GUARD-1 -> SHOW, prescaler cleared.
  - SHOW: an[digit_idx] asserted. The prescaler counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 -> GUARD, and digit_idx increments, wrapping DIGITS-1 -> 0.
  - The first cycle after reset release with en=1 is GUARD for digit 0.
- en==0: counters and state hold. On the next edge an is deasserted and seg/dp go unlit. When en returns, the scan resumes from the held state.
- Output registration: seg/dp/an reflect the registered state plus the shadow data, with one cycle of latency (registered outputs, no combinational path from inputs).
- Hex decode (active-high, before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Digit dark: digit i is dark (seg and dp unlit; anode still asserted) if either:
  - blank_mask[i]==1; or
  - lz_en==1, i>0, and the shadow nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never suppressed by lz_en.
- lamp_test==1: seg=7F and dp lit for the active digit, overriding blanking and suppression. It does not alter scan timing or anode timing. It is sampled every cycle, with no shadow.
- Polarity: applied at the final output register. In GUARD, an is inactive and seg/dp are unlit.
- Mid-operation load: new data takes effect on the next cycle, even mid-SHOW. The scan position is unchanged.

Test Plan:
- Bench parameters for all scenarios: DIGITS=4, REFRESH_DIV=4, GUARD=1, both active-low.
- Reset and first digit: hold reset=0 for 3 cycles -> an=4'b1111, seg=7'h7F, dp=1. Release with en=1 and load value=16'h1234 -> after the GUARD cycle, an=4'b1110 and seg=~7'h66 (digit 4) for exactly 4 cycles.
- Full scan: continue the same run -> the sequence is digits 0,1,2,3,0, each with 1 guard cycle plus 4 show cycles. seg shows ~66, ~4F, ~5B, ~06; digit_idx wraps 3 -> 0. Period = 20 cycles.
- Leading-zero suppression: load value=16'h0050, lz_en=1 -> digits 3 and 2 are dark (seg=7F) with their anodes still pulsed. Digit 1 shows ~6D, digit 0 shows ~3F. With value=0, digit 0 shows ~3F.
- Blank mask, decimal point and lamp test: blank_mask=4'b0100 and dp_in=4'b0001 -> digit 2 is dark and digit 0 has dp=0. Assert lamp_test -> every shown digit gives seg=7'h00 and dp=0, including digit 2.
- en pause and reset mid-scan: drop en mid-SHOW of digit 1 for 10 cycles -> next cycle an=1111. Resume -> digit 1 finishes its remaining show cycles. Apply reset=0 for one cycle mid-SHOW -> next cycle digit_idx=0, outputs inactive, and the shadow is cleared.

Source files
------------

// File: rtl/seg_scan_controller.sv
// Multi-digit seven-segment scan driver: shadowed display data, guarded digit
// multiplexing, blanking, leading-zero suppression, lamp test and pin polarity.
module seg_scan_controller #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned REFRESH_DIV    = 50000,
   parameter int unsigned GUARD          = 2,
   parameter bit          AN_ACTIVE_LOW  = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       load,
   input  logic [4*DIGITS-1:0]        value,
   input  logic [DIGITS-1:0]          dp_in,
   input  logic [DIGITS-1:0]          blank_mask,
   input  logic                       lz_en,
   input  logic                       lamp_test,
   output logic [6:0]                 seg,
   output logic                       dp,
   output logic [DIGITS-1:0]          an,
   output logic [$clog2(DIGITS)-1:0]  digit_idx
);

   localparam int IDX_W = $clog2(DIGITS);
   localparam int PSC_W = $clog2(REFRESH_DIV);
   localparam int GRD_W = (GUARD > 1) ? $clog2(GUARD) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(REFRESH_DIV - 1);
   localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD - 1);

   localparam logic [0:0] ST_GUARD = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   // XOR masks that turn the internal active-high view into pin levels
   localparam logic [6:0]        SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic              DP_POL  = SEG_ACTIVE_LOW;
   localparam logic [DIGITS-1:0] AN_POL  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [4*DIGITS-1:0] val_sh;
   logic [DIGITS-1:0]   dp_sh;
   logic [DIGITS-1:0]   blank_sh;
   logic                lz_sh;

   logic [0:0]          state;
   logic [GRD_W-1:0]    gcnt;
   logic [PSC_W-1:0]    psc;
   logic [IDX_W-1:0]    cur_idx;

   logic [DIGITS-1:0]   lz_dark;
   logic                zero_above;
   logic [3:0]          nib;
   logic                dark;
   logic [6:0]          seg_ah;
   logic                dp_ah;
   logic [DIGITS-1:0]   an_ah;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         val_sh   <= '0;
         dp_sh    <= '0;
         blank_sh <= '0;
         lz_sh    <= 1'b0;
      end else if (load) begin
         val_sh   <= value;
         dp_sh    <= dp_in;
         blank_sh <= blank_mask;
         lz_sh    <= lz_en;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= ST_GUARD;
         gcnt    <= '0;
         psc     <= '0;
         cur_idx <= '0;
      end else if (en) begin
         unique case (state)
            ST_GUARD: begin
               if (gcnt == GRD_LAST) begin
                  state <= ST_SHOW;
                  gcnt  <= '0;
                  psc   <= '0;
               end else begin
                  gcnt <= gcnt + GRD_W'(1);
               end
            end
            ST_SHOW: begin
               if (psc == PSC_LAST) begin
                  state   <= ST_GUARD;
                  gcnt    <= '0;
                  psc     <= '0;
                  cur_idx <= (cur_idx == IDX_LAST) ? '0 : cur_idx + IDX_W'(1);
               end else begin
                  psc <= psc + PSC_W'(1);
               end
            end
            default: state <= ST_GUARD;
         endcase
      end
   end

   // Digit i is a leading zero when nibbles i..DIGITS-1 are all zero; digit 0 never is.
   // NOTE: every always_comb output is defaulted first so no path leaves a latch.
   always_comb begin
      lz_dark    = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (val_sh[4*i +: 4] == 4'h0);
         lz_dark[i] = lz_sh & zero_above;
      end
   end

   always_comb begin
      nib    = val_sh[{cur_idx, 2'b00} +: 4];
      dark   = blank_sh[cur_idx] | lz_dark[cur_idx];
      seg_ah = 7'h00;
      dp_ah  = 1'b0;
      an_ah  = '0;
      if (en && state == ST_SHOW) begin
         an_ah[cur_idx] = 1'b1;
         if (lamp_test) begin
            seg_ah = 7'h7F;
            dp_ah  = 1'b1;
         end else if (!dark) begin
            seg_ah = hex7(nib);
            dp_ah  = dp_sh[cur_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         seg       <= SEG_POL;
         dp        <= DP_POL;
         an        <= AN_POL;
         digit_idx <= '0;
      end else begin
         seg       <= seg_ah ^ SEG_POL;
         dp        <= dp_ah ^ DP_POL;
         an        <= an_ah ^ AN_POL;
         digit_idx <= cur_idx;
      end
   end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: a slot-position model predicts every
// output cycle, with fixed-value checks at the points of interest.
module tb_seg_scan_controller;

   localparam int DIGITS      = 4;
   localparam int REFRESH_DIV = 4;
   localparam int GUARD       = 1;
   localparam int SLOT        = GUARD + REFRESH_DIV;

   logic        clk = 1'b0;
   logic        reset, en, load, lz_en, lamp_test;
   logic [15:0] value;
   logic [3:0]  dp_in, blank_mask;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [1:0]  digit_idx;

   always #5 clk = ~clk;

   seg_scan_controller #(
      .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .GUARD(GUARD),
      .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .value(value),
      .dp_in(dp_in), .blank_mask(blank_mask), .lz_en(lz_en), .lamp_test(lamp_test),
      .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [1:0] idx;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model: position within a GUARD+REFRESH_DIV slot and the digit owning the slot
   int          m_pos, m_digit;
   logic [15:0] m_val;
   logic [3:0]  m_dp, m_blank;
   logic        m_lz;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [6:0] hex_ref(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   function automatic exp_t model_out();
      exp_t        e;
      logic [15:0] upper;
      logic        dark;
      logic [6:0]  s_ah;
      logic        d_ah;
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.idx = 2'(m_digit);
      if (!reset) begin
         e.idx = 2'd0;
      end else if (en && m_pos >= GUARD) begin
         upper = m_val >> (4 * m_digit);
         dark  = m_blank[m_digit] || (m_lz && m_digit > 0 && upper == 16'h0);
         if (lamp_test) begin
            s_ah = 7'h7F;
            d_ah = 1'b1;
         end else if (dark) begin
            s_ah = 7'h00;
            d_ah = 1'b0;
         end else begin
            s_ah = hex_ref(upper[3:0]);
            d_ah = m_dp[m_digit];
         end
         e.an  = ~(4'b0001 << m_digit);
         e.seg = ~s_ah;
         e.dp  = ~d_ah;
      end
      return e;
   endfunction

   task automatic model_update();
      if (!reset) begin
         m_pos = 0; m_digit = 0; m_val = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;
      end else begin
         if (load) begin
            m_val = value; m_dp = dp_in; m_blank = blank_mask; m_lz = lz_en;
         end
         if (en) begin
            m_pos++;
            if (m_pos == SLOT) begin
               m_pos   = 0;
               m_digit = (m_digit + 1) % DIGITS;
            end
         end
      end
   endtask

   task automatic step();
      exp_t e;
      sb_q.push_back(model_out());
      model_update();
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("sb_an",  32'(an),        32'(e.an));
      check("sb_seg", 32'(seg),       32'(e.seg));
      check("sb_dp",  32'(dp),        32'(e.dp));
      check("sb_idx", 32'(digit_idx), 32'(e.idx));
   endtask

   task automatic expect_out(input string tag, input logic [3:0] a,
                             input logic [6:0] s, input logic d);
      check({tag, "_an"},  32'(an),  32'(a));
      check({tag, "_seg"}, 32'(seg), 32'(s));
      check({tag, "_dp"},  32'(dp),  32'(d));
   endtask

   // Advance until the next edge presents the first SHOW cycle of digit d, then take it
   task automatic goto_show(input int d);
      int n = 0;
      while (!(m_digit == d && m_pos == GUARD) && n < 4 * SLOT) begin
         step();
         n++;
      end
      if (n >= 4 * SLOT) begin
         n_checks++;
         n_fail++;
         $display("FAIL goto_show%0d: no slot for digit after %0d cycles", d, n);
      end
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [6:0] scan_tbl [5];
      logic [3:0] an_exp;
      scan_tbl[0] = 7'h66; scan_tbl[1] = 7'h4F; scan_tbl[2] = 7'h5B;
      scan_tbl[3] = 7'h06; scan_tbl[4] = 7'h66;

      reset = 1'b0; en = 1'b0; load = 1'b0; value = '0; dp_in = '0;
      blank_mask = '0; lz_en = 1'b0; lamp_test = 1'b0;
      m_pos = 0; m_digit = 0; m_val = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;

      repeat (3) step();
      expect_out("reset", 4'hF, 7'h7F, 1'b1);
      check("reset_idx", 32'(digit_idx), 32'd0);

      // Release with load of 0x1234: one guard cycle, then digits 0..3,0 at four cycles each
      reset = 1'b1; en = 1'b1; load = 1'b1; value = 16'h1234;
      step();
      load = 1'b0;
      expect_out("first_guard", 4'hF, 7'h7F, 1'b1);
      for (int k = 0; k < 5; k++) begin
         an_exp = ~(4'b0001 << (k % 4));
         for (int c = 0; c < REFRESH_DIV; c++) begin
            step();
            expect_out($sformatf("scan%0d_%0d", k, c), an_exp, ~scan_tbl[k], 1'b1);
            check($sformatf("scan%0d_%0d_idx", k, c), 32'(digit_idx), 32'(k % 4));
         end
         if (k < 4) begin
            step();
            expect_out($sformatf("scan%0d_guard", k), 4'hF, 7'h7F, 1'b1);
         end
      end

      // Leading-zero suppression
      lz_en = 1'b1; value = 16'h0050; load = 1'b1;
      step();
      load = 1'b0;
      goto_show(3); expect_out("lz_d3", 4'b0111, 7'h7F, 1'b1);
      goto_show(2); expect_out("lz_d2", 4'b1011, 7'h7F, 1'b1);
      goto_show(1); expect_out("lz_d1", 4'b1101, ~7'h6D, 1'b1);
      goto_show(0); expect_out("lz_d0", 4'b1110, ~7'h3F, 1'b1);
      value = 16'h0000; load = 1'b1;
      step();
      load = 1'b0;
      goto_show(0); expect_out("lz0_d0", 4'b1110, ~7'h3F, 1'b1);
      goto_show(1); expect_out("lz0_d1", 4'b1101, 7'h7F, 1'b1);

      // Blank mask, decimal point, then lamp test
      lz_en = 1'b0; value = 16'h1234; blank_mask = 4'b0100; dp_in = 4'b0001; load = 1'b1;
      step();
      load = 1'b0;
      goto_show(2); expect_out("blank_d2", 4'b1011, 7'h7F, 1'b1);
      goto_show(0); expect_out("dp_d0", 4'b1110, ~7'h66, 1'b0);
      goto_show(1); expect_out("dp_d1", 4'b1101, ~7'h4F, 1'b1);
      lamp_test = 1'b1;
      goto_show(2); expect_out("lamp_d2", 4'b1011, 7'h00, 1'b0);
      goto_show(3); expect_out("lamp_d3", 4'b0111, 7'h00, 1'b0);
      repeat (REFRESH_DIV) step();
      expect_out("lamp_guard", 4'hF, 7'h7F, 1'b1);
      lamp_test = 1'b0;

      // Pause mid-SHOW of digit 1, then resume for the two remaining show cycles
      goto_show(1);
      step();
      en = 1'b0;
      step();
      expect_out("pause", 4'hF, 7'h7F, 1'b1);
      check("pause_idx", 32'(digit_idx), 32'd1);
      repeat (9) step();
      en = 1'b1;
      step(); expect_out("resume_a", 4'b1101, ~7'h4F, 1'b1);
      step(); expect_out("resume_b", 4'b1101, ~7'h4F, 1'b1);
      step(); expect_out("resume_guard", 4'hF, 7'h7F, 1'b1);

      // One-cycle reset mid-SHOW clears position and shadow data
      goto_show(2);
      step();
      reset = 1'b0;
      step();
      expect_out("midrst", 4'hF, 7'h7F, 1'b1);
      check("midrst_idx", 32'(digit_idx), 32'd0);
      reset = 1'b1;
      step(); expect_out("midrst_guard", 4'hF, 7'h7F, 1'b1);
      step(); expect_out("midrst_d0", 4'b1110, ~7'h3F, 1'b1);
      goto_show(2); expect_out("midrst_d2", 4'b1011, ~7'h3F, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
